// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter/sequencer: pops one device FIFO head and pushes it to its decoded destination(s).
// Latency: pending seen in IDLE at edge N -> pop in cycle N+1 -> push in cycle N+2; one word per 3 cycles.
// Backpressure: none on the bus; a grant is abandoned if the owner's pending flag drops before its pop.
module bus_rr_arbiter #(
  parameter int         devices   = 4,
  parameter int         width     = 16,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [devices-1:0]        pndng,
  input  logic [devices*width-1:0]  D_pop,
  output logic [devices-1:0]        pop,
  output logic [devices-1:0]        push,
  output logic [width-1:0]          D_push,
  output logic [devices-1:0]        grant,
  output logic                      busy,
  output logic                      drop
);

  localparam int IW = (devices > 1) ? $clog2(devices) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        last_q, last_d;
  logic [IW-1:0]        src_q, src_d;
  logic [devices-1:0]   grant_q, grant_d;
  logic [devices-1:0]   push_q, push_d;
  logic [width-1:0]     data_q, data_d;
  logic                 drop_q, drop_d;

  logic [IW-1:0]        winner;
  logic [IW-1:0]        idx;
  logic [width-1:0]     words [devices];
  logic [width-1:0]     head;
  logic [7:0]           dest;

  genvar gi;
  generate
    for (gi = 0; gi < devices; gi++) begin : g_words
      assign words[gi] = D_pop[gi*width +: width];
    end
  endgenerate

  // Granted device's FIFO head and its destination address field.
  always_comb begin
    head = words[src_q];
    dest = head[width-1 -: 8];
  end

  // Scan downward so the last hit is the first pending device after the pointer.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int k = devices; k >= 1; k--) begin
      idx = IW'((int'(last_q) + k) % devices);
      if (pndng[idx]) winner = idx;
    end
  end

  // Next-state and strobe decode; pop is the only output qualified by the live pending flag.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    src_d   = src_q;
    grant_d = grant_q;
    push_d  = '0;
    data_d  = data_q;
    drop_d  = 1'b0;
    pop     = '0;
    case (state_q)
      IDLE: begin
        if (|pndng) begin
          src_d   = winner;
          last_d  = winner;
          grant_d = devices'(1) << winner;
          state_d = POP;
        end
      end
      POP: begin
        if (pndng[src_q]) begin
          pop     = grant_q;
          data_d  = head;
          state_d = PUSH;
          if (dest == broadcast) begin
            push_d = ~grant_q;
          end else if (int'(dest) < devices && int'(dest) != int'(src_q)) begin
            push_d = devices'(1) << dest;
          end else begin
            drop_d = 1'b1;
          end
        end else begin
          // Owner emptied before its pop: give up the slot, keep the pointer advanced.
          grant_d = '0;
          state_d = IDLE;
        end
      end
      PUSH: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards any word latched but not yet pushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= IW'(devices - 1);
      src_q   <= '0;
      grant_q <= '0;
      push_q  <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      src_q   <= src_d;
      grant_q <= grant_d;
      push_q  <= push_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign grant  = grant_q;
  assign push   = push_q;
  assign D_push = data_q;
  assign drop   = drop_q;
  assign busy   = (state_q != IDLE);

endmodule
